// File: rtl/fma_round_pack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fma_pkg
//  Description : Shared FP32 field widths, rounding modes, special encodings
//                and stage structure for the FMA round/pack block.
//  Revision    : 1.0 - initial release
// ============================================================================
package fma_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int MANT_W = SIG_W + 3;
    localparam int WORD_W = 1 + EXP_W + FRAC_W;

    localparam logic [EXP_W:0] EXP_MAX = 9'd255;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } rnd_mode_e;

    // Magnitudes only; the sign bit is prepended at pack time.
    localparam logic [WORD_W-2:0] MAX_FINITE = 31'h7F7F_FFFF;
    localparam logic [WORD_W-2:0] INF        = 31'h7F80_0000;

    // Flag vectors are {overflow, underflow, inexact}.
    localparam logic [2:0] FLAGS_NONE = 3'b000;
    localparam logic [2:0] FLAGS_OVF  = 3'b101;
    localparam logic [2:0] FLAGS_UNF  = 3'b011;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             inc;
        rnd_mode_e        mode;
        logic             is_zero;
        logic             ovf;
        logic             unf;
        logic             grs;
    } s1_t;

    function automatic logic [WORD_W-1:0] overflow_result(input rnd_mode_e mode,
                                                          input logic      sign);
        logic to_inf;
        case (mode)
            RM_RNE:  to_inf = 1'b1;
            RM_RTZ:  to_inf = 1'b0;
            RM_RUP:  to_inf = ~sign;
            default: to_inf = sign;
        endcase
        return {sign, (to_inf ? INF : MAX_FINITE)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fma_round_pack_if.sv
`default_nettype none
// ============================================================================
//  Module      : fma_round_pack_if
//  Description : Input/output handshake bundle of the FMA round/pack stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fma_round_pack_if;
    import fma_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [EXP_W-1:0]     in_exp;
    logic                 in_exc;
    logic [MANT_W-1:0]    in_mant;
    logic [1:0]           rnd_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_W-1:0]    out_result;
    logic [2:0]           out_flags;

    // Environment side: produces operands, consumes results.
    modport master (
        output in_valid, in_sign, in_exp, in_exc, in_mant, rnd_mode, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    // Round/pack block side.
    modport slave (
        input  in_valid, in_sign, in_exp, in_exc, in_mant, rnd_mode, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

endinterface
`default_nettype wire

// File: rtl/fma_round_pack_round_decide.sv
`default_nettype none
// ============================================================================
//  Module      : round_decide
//  Description : Combinational round-increment decision from mode, sign and
//                the L/G/R/S bits of the normalised significand.
//  Revision    : 1.0 - initial release
// ============================================================================
module round_decide
    import fma_pkg::*;
(
    input  rnd_mode_e mode,
    input  logic      sign,
    input  logic      lsb,
    input  logic      guard,
    input  logic      round_bit,
    input  logic      sticky,
    output logic      inc
);

    logic w_any;

    always_comb begin
        w_any = guard | round_bit | sticky;
        inc   = 1'b0;
        case (mode)
            // Tie (G=1, R=S=0) rounds up only when it makes the LSB even.
            RM_RNE:  inc = guard & (round_bit | sticky | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & w_any;
            RM_RDN:  inc = sign & w_any;
            default: inc = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fma_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fma_round_pack
//  Description : Two-stage FP32 rounding and packing back end of an FMA:
//                S1 decides the increment, S2 applies carry and packs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fma_round_pack
    import fma_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    fma_round_pack_if.slave     bus
);

    rnd_mode_e          w_mode;
    logic               w_inc;
    logic               w_s1_adv;
    logic               w_s2_adv;
    s1_t                w_s1_next;
    s1_t                r_s1;
    logic               r_s1_valid;
    logic               r_s2_valid;
    logic [WORD_W-1:0]  r_result;
    logic [2:0]         r_flags;

    logic [SIG_W:0]     w_sum;
    logic               w_carry;
    logic [FRAC_W-1:0]  w_frac;
    logic [EXP_W:0]     w_exp9;
    logic               w_ovf;
    logic [WORD_W-1:0]  w_result;
    logic [2:0]         w_flags;

    // S2 is the output register, so its advance is the downstream handshake.
    assign w_s2_adv     = ~r_s2_valid | bus.out_ready;
    assign w_s1_adv     = ~r_s1_valid | w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    assign w_mode = rnd_mode_e'(bus.rnd_mode);

    round_decide u_round_decide (
        .mode      (w_mode),
        .sign      (bus.in_sign),
        .lsb       (bus.in_mant[3]),
        .guard     (bus.in_mant[2]),
        .round_bit (bus.in_mant[1]),
        .sticky    (bus.in_mant[0]),
        .inc       (w_inc)
    );

    always_comb begin
        w_s1_next         = '0;
        w_s1_next.sign    = bus.in_sign;
        w_s1_next.exp     = bus.in_exp;
        w_s1_next.sig     = bus.in_mant[MANT_W-1:3];
        w_s1_next.inc     = w_inc;
        w_s1_next.mode    = w_mode;
        w_s1_next.is_zero = (bus.in_mant == '0);
        w_s1_next.ovf     = bus.in_exc | (bus.in_exp == EXP_MAX[EXP_W-1:0]);
        w_s1_next.unf     = (bus.in_exp == '0);
        w_s1_next.grs     = |bus.in_mant[2:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1 <= w_s1_next;
            end
        end
    end

    // Carry out of the 24-bit significand means 1.11..1 rounded to 10.00..0.
    always_comb begin
        w_sum    = {1'b0, r_s1.sig} + {{SIG_W{1'b0}}, r_s1.inc};
        w_carry  = w_sum[SIG_W];
        w_frac   = w_carry ? w_sum[SIG_W-1:1] : w_sum[FRAC_W-1:0];
        w_exp9   = {1'b0, r_s1.exp} + {{EXP_W{1'b0}}, w_carry};
        w_ovf    = r_s1.ovf | (w_exp9 >= EXP_MAX);
        w_result = {r_s1.sign, w_exp9[EXP_W-1:0], w_frac};
        w_flags  = {2'b00, r_s1.grs};
        if (r_s1.is_zero) begin
            w_result = {r_s1.sign, {(WORD_W-1){1'b0}}};
            w_flags  = FLAGS_NONE;
        end else if (w_ovf) begin
            w_result = overflow_result(r_s1.mode, r_s1.sign);
            w_flags  = FLAGS_OVF;
        end else if (r_s1.unf) begin
            w_result = {r_s1.sign, {(WORD_W-1){1'b0}}};
            w_flags  = FLAGS_UNF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign bus.out_valid  = r_s2_valid;
    assign bus.out_result = r_result;
    assign bus.out_flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fma_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fma_round_pack
//  Description : Self-checking bench for fma_round_pack against an arithmetic
//                reference model of FP32 rounding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_round_pack;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic        exc;
        logic [26:0] mant;
        logic [1:0]  mode;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fma_round_pack_if bus();

    fma_round_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic x,
                                input logic [26:0] m, input logic [1:0] md);
        vec_t v;
        v.sign = s; v.exp = e; v.exc = x; v.mant = m; v.mode = md;
        return v;
    endfunction

    // Reference: value-level rounding of sig + rem/8, returns {flags, result}.
    function automatic logic [34:0] model(input vec_t v);
        int unsigned sig, rem, ex;
        bit up, to_inf;
        sig = 32'(v.mant[26:3]);
        rem = 32'(v.mant[2:0]);
        ex  = 32'(v.exp);
        if (v.mant == 27'd0) return {3'b000, v.sign, 31'd0};
        case (v.mode)
            2'd0:    up = (rem > 4) || (rem == 4 && (sig % 2) == 1);
            2'd1:    up = 1'b0;
            2'd2:    up = !v.sign && rem != 0;
            default: up = v.sign && rem != 0;
        endcase
        sig = sig + (up ? 1 : 0);
        if (sig == (1 << 24)) begin
            sig = 1 << 23;
            ex  = ex + 1;
        end
        if (v.exc || v.exp == 8'd255 || ex >= 255) begin
            to_inf = (v.mode == 2'd0) || (v.mode == 2'd2 && !v.sign) || (v.mode == 2'd3 && v.sign);
            return {3'b101, v.sign, (to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF)};
        end
        if (v.exp == 8'd0) return {3'b011, v.sign, 31'd0};
        return {2'b00, (rem != 0), v.sign, 8'(ex), 23'(sig % (1 << 23))};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.sign = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0:       v.exp = 8'h00;
            1:       v.exp = 8'hFE;
            2:       v.exp = 8'hFF;
            default: v.exp = 8'($urandom_range(1, 254));
        endcase
        v.exc = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 7))
            0:       v.mant = 27'd0;
            1:       v.mant = {24'hFF_FFFF, 3'($urandom)};
            default: v.mant = {1'b1, 26'($urandom)};
        endcase
        v.mode = 2'($urandom_range(0, 3));
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.in_sign  = v.sign;
        bus.in_exp   = v.exp;
        bus.in_exc   = v.exc;
        bus.in_mant  = v.mant;
        bus.rnd_mode = v.mode;
    endtask

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        apply(mk(0, 8'h00, 0, 27'd0, 2'd0));
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_result !== 32'd0 || bus.out_flags !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: result=%h flags=%b, required 0/000", bus.out_result, bus.out_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t        dv[14];
        logic [34:0] de[14];
        dv[0]  = mk(0, 8'h7F, 0, 27'h400_0000, 2'd0); de[0]  = {3'b000, 32'h3F80_0000};
        dv[1]  = mk(0, 8'h7F, 0, 27'h400_0004, 2'd0); de[1]  = {3'b001, 32'h3F80_0000};
        dv[2]  = mk(0, 8'h7F, 0, 27'h400_000C, 2'd0); de[2]  = {3'b001, 32'h3F80_0002};
        dv[3]  = mk(0, 8'h7F, 0, 27'h7FF_FFFC, 2'd0); de[3]  = {3'b001, 32'h4000_0000};
        dv[4]  = mk(0, 8'hFE, 0, 27'h7FF_FFFC, 2'd0); de[4]  = {3'b101, 32'h7F80_0000};
        dv[5]  = mk(0, 8'hFE, 0, 27'h7FF_FFFC, 2'd1); de[5]  = {3'b001, 32'h7F7F_FFFF};
        dv[6]  = mk(1, 8'hFE, 1, 27'h7FF_FFFC, 2'd3); de[6]  = {3'b101, 32'hFF80_0000};
        dv[7]  = mk(1, 8'h55, 0, 27'h000_0000, 2'd2); de[7]  = {3'b000, 32'h8000_0000};
        dv[8]  = mk(0, 8'h00, 0, 27'h400_0001, 2'd0); de[8]  = {3'b011, 32'h0000_0000};
        dv[9]  = mk(0, 8'hFF, 0, 27'h400_0000, 2'd2); de[9]  = {3'b101, 32'h7F80_0000};
        dv[10] = mk(1, 8'hFF, 0, 27'h400_0000, 2'd2); de[10] = {3'b101, 32'hFF7F_FFFF};
        dv[11] = mk(0, 8'h7F, 0, 27'h400_0001, 2'd2); de[11] = {3'b001, 32'h3F80_0001};
        dv[12] = mk(1, 8'h7F, 0, 27'h400_0001, 2'd3); de[12] = {3'b001, 32'hBF80_0001};
        dv[13] = mk(0, 8'h7F, 0, 27'h400_0001, 2'd3); de[13] = {3'b001, 32'h3F80_0000};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(dv[i]);
            bus.in_valid = 1'b1;
            bus.out_ready = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_accept: in_ready=%b, required 1", i, bus.in_ready);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_latency_early: out_valid=%b, required 0", i, bus.out_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_flags, bus.out_result} !== de[i]) begin
                errors++;
                $display("FAIL dir%0d_result: valid=%b got %b/%h, required 1 %b/%h", i, bus.out_valid,
                         bus.out_flags, bus.out_result, de[i][34:32], de[i][31:0]);
            end
        end
        idle(3);
    endtask

    task automatic test_throughput();
        logic [34:0] q[$];
        logic [34:0] e;
        vec_t v;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            v = rand_vec();
            apply(v);
            bus.in_valid = (cyc < 6);
            bus.out_ready = 1'b1;
            #1;
            if (cyc < 6) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tput_in_ready cyc%0d: got %b, required 1", cyc, bus.in_ready);
                end
                q.push_back(model(v));
            end
            if (cyc >= 2 && cyc < 8) begin
                checks++;
                e = (q.size() > 0) ? q.pop_front() : 35'd0;
                if (bus.out_valid !== 1'b1 || {bus.out_flags, bus.out_result} !== e) begin
                    errors++;
                    $display("FAIL tput_out cyc%0d: valid=%b got %b/%h, required 1 %b/%h", cyc, bus.out_valid,
                             bus.out_flags, bus.out_result, e[34:32], e[31:0]);
                end
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        vec_t        v[4];
        logic [34:0] q[$];
        logic [34:0] hold, e;
        logic        held;
        int          sent, got;
        sent = 0; got = 0; held = 1'b0; hold = '0;
        for (int i = 0; i < 4; i++) v[i] = mk(1'($urandom), 8'($urandom_range(1, 250)), 0, {1'b1, 26'($urandom)}, 2'($urandom));
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            bus.in_valid = (sent < 4);
            if (sent < 4) apply(v[sent]);
            bus.out_ready = (cyc >= 5);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stall cyc%0d: in_ready=%b out_valid=%b, required 0/1", cyc, bus.in_ready, bus.out_valid);
                end
            end
            if (held) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.out_flags, bus.out_result} !== hold) begin
                    errors++;
                    $display("FAIL b2b_hold cyc%0d: got %b/%h, required %b/%h", cyc, bus.out_flags, bus.out_result, hold[34:32], hold[31:0]);
                end
            end
            held = bus.out_valid && !bus.out_ready;
            hold = {bus.out_flags, bus.out_result};
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                e = (q.size() > 0) ? q.pop_front() : 35'd0;
                if ({bus.out_flags, bus.out_result} !== e) begin
                    errors++;
                    $display("FAIL b2b_order #%0d: got %b/%h, required %b/%h", got, bus.out_flags, bus.out_result, e[34:32], e[31:0]);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(v[sent]));
                sent++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count: delivered %0d, required 4", got);
        end
        idle(2);
    endtask

    task automatic test_random();
        localparam int N = 300;
        logic [34:0] q[$];
        logic [34:0] hold, e;
        logic        held;
        vec_t        v;
        int          sent, got, cyc;
        sent = 0; got = 0; cyc = 0; held = 1'b0; hold = '0;
        v = rand_vec();
        while ((sent < N || got < sent) && cyc < 4000) begin
            @(negedge clk);
            bus.in_valid = (sent < N) && ($urandom_range(0, 9) < 7);
            apply(v);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (held) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.out_flags, bus.out_result} !== hold) begin
                    errors++;
                    $display("FAIL rand_hold cyc%0d: got %b/%h, required %b/%h", cyc, bus.out_flags, bus.out_result, hold[34:32], hold[31:0]);
                end
            end
            held = bus.out_valid && !bus.out_ready;
            hold = {bus.out_flags, bus.out_result};
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_spurious cyc%0d: got %b/%h, required no output", cyc, bus.out_flags, bus.out_result);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_flags, bus.out_result} !== e) begin
                        errors++;
                        $display("FAIL rand_result #%0d: got %b/%h, required %b/%h", got, bus.out_flags, bus.out_result, e[34:32], e[31:0]);
                    end
                    got++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(v));
                sent++;
                v = rand_vec();
            end
            cyc++;
        end
        checks++;
        if (got != N) begin
            errors++;
            $display("FAIL rand_count: delivered %0d, required %0d", got, N);
        end
        idle(2);
    endtask

    task automatic test_reset_flight();
        int stale;
        stale = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            apply(mk(0, 8'h70, 0, {1'b1, 26'($urandom)}, 2'd0));
            bus.in_valid = 1'b1;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flight_full: out_valid=%b in_ready=%b, required 1/0", bus.out_valid, bus.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 32'd0 || bus.out_flags !== 3'd0) begin
            errors++;
            $display("FAIL flight_async_reset: out_valid=%b in_ready=%b result=%h flags=%b, required 0/1/0/000",
                     bus.out_valid, bus.in_ready, bus.out_result, bus.out_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus.out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL flight_stale: %0d cycles with out_valid after release, required 0", stale);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        apply(mk(0, 8'h00, 0, 27'd0, 2'd0));
        test_reset();
        test_directed();
        test_throughput();
        test_back_to_back();
        test_random();
        test_reset_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
